// File: rtl/mac_share_arbiter_if.sv
// Bundle of the requester, MAC and response handshakes around the MAC share arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mac_share_arbiter_if #(
    parameter int width_p  = 24,
    parameter int num_ch_p = 4
) ();
    logic [num_ch_p-1:0]         req_valid_i;
    logic [num_ch_p-1:0]         req_last_i;
    logic [num_ch_p*width_p-1:0] req_data_i;
    logic [num_ch_p-1:0]         req_ready_o;
    logic                        mac_valid_o;
    logic [width_p-1:0]          mac_data_o;
    logic                        mac_ready_i;
    logic                        mac_valid_i;
    logic [width_p-1:0]          mac_data_i;
    logic                        mac_ready_o;
    logic [num_ch_p-1:0]         resp_valid_o;
    logic [width_p-1:0]          resp_data_o;
    logic [num_ch_p-1:0]         resp_ready_i;
    logic                        busy_o;
    logic                        err_o;

    modport slave (
        input  req_valid_i, req_last_i, req_data_i, mac_ready_i,
        input  mac_valid_i, mac_data_i, resp_ready_i,
        output req_ready_o, mac_valid_o, mac_data_o, mac_ready_o,
        output resp_valid_o, resp_data_o, busy_o, err_o
    );

    modport master (
        output req_valid_i, req_last_i, req_data_i, mac_ready_i,
        output mac_valid_i, mac_data_i, resp_ready_i,
        input  req_ready_o, mac_valid_o, mac_data_o, mac_ready_o,
        input  resp_valid_o, resp_data_o, busy_o, err_o
    );
endinterface

// File: rtl/mac_share_arbiter.sv
// Shares one valid/ready MAC datapath among num_ch_p requesters with burst-granular
// round-robin arbitration; a tag FIFO routes MAC results back to their issuing channel.
// The interface instance must be built with the same width_p / num_ch_p as this module.
module mac_share_arbiter #(
    parameter int width_p     = 24,
    parameter int num_ch_p    = 4,
    parameter int tag_depth_p = 4
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    mac_share_arbiter_if.slave  bus
);
    localparam int id_w_lp  = $clog2(num_ch_p);
    localparam int ptr_w_lp = $clog2(tag_depth_p);
    localparam logic [num_ch_p-1:0]  one_lp   = {{(num_ch_p-1){1'b0}}, 1'b1};
    localparam logic [ptr_w_lp:0]    depth_lp = (ptr_w_lp+1)'(tag_depth_p);

    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t               state_r, state_s;
    logic [id_w_lp-1:0]   ptr_r, ptr_s, lock_r, lock_s;
    logic [id_w_lp-1:0]   tags_r [tag_depth_p];
    logic [ptr_w_lp-1:0]  wr_r, rd_r;
    logic [ptr_w_lp:0]    cnt_r;
    logic                 err_r;

    logic                 found_s, has_grant_s, can_issue_s, issue_s, last_s;
    logic                 full_s, nonempty_s, pop_s;
    logic [id_w_lp-1:0]   pick_s, grant_s, head_s;

    // Channel after c, wrapping at num_ch_p (which need not be a power of two).
    function automatic logic [id_w_lp-1:0] next_ch(input logic [id_w_lp-1:0] c);
        if (int'(c) == num_ch_p - 1) begin
            return '0;
        end else begin
            return c + 1'b1;
        end
    endfunction

    assign full_s      = (cnt_r == depth_lp);
    assign nonempty_s  = (cnt_r != '0);
    assign head_s      = tags_r[rd_r];
    assign can_issue_s = bus.mac_ready_i & ~full_s;
    assign pop_s       = nonempty_s & bus.mac_valid_i & bus.resp_ready_i[head_s];

    // Round-robin search: first valid channel at or after the pointer, wrapping.
    always_comb begin
        int idx;
        found_s = 1'b0;
        pick_s  = '0;
        idx     = 0;
        for (int i = 0; i < num_ch_p; i++) begin
            idx = (int'(ptr_r) + i) % num_ch_p;
            if (!found_s && bus.req_valid_i[idx]) begin
                found_s = 1'b1;
                pick_s  = id_w_lp'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant selection and issue-side outputs; a burst owner keeps the grant even when idle.
    always_comb begin
        grant_s         = pick_s;
        has_grant_s     = 1'b0;
        bus.req_ready_o = '0;
        bus.mac_valid_o = 1'b0;
        bus.mac_data_o  = '0;
        if (state_r == BURST) begin
            grant_s     = lock_r;
            has_grant_s = reset_n_i;
        end else begin
            grant_s     = pick_s;
            has_grant_s = found_s & reset_n_i;
        end
        if (has_grant_s) begin
            bus.req_ready_o = can_issue_s ? (one_lp << grant_s) : '0;
            bus.mac_valid_o = bus.req_valid_i[grant_s];
            bus.mac_data_o  = bus.req_data_i[int'(grant_s)*width_p +: width_p];
        end else begin
            bus.req_ready_o = '0;
        end
        last_s  = bus.req_last_i[grant_s];
        issue_s = has_grant_s & bus.req_valid_i[grant_s] & can_issue_s;
    end

    // Next-state logic: lock on a non-last beat, release and rotate on the last beat.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        lock_s  = lock_r;
        case (state_r)
            IDLE: begin
                if (issue_s && last_s) begin
                    ptr_s = next_ch(grant_s);
                end else if (issue_s) begin
                    lock_s  = grant_s;
                    state_s = BURST;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if (issue_s && last_s) begin
                    ptr_s   = next_ch(lock_r);
                    state_s = IDLE;
                end else begin
                    state_s = BURST;
                end
            end
            default: begin
                state_s = IDLE;
                ptr_s   = '0;
                lock_s  = '0;
            end
        endcase
    end

    // Result routing: the head tag selects which channel sees the MAC result.
    always_comb begin
        bus.resp_valid_o = '0;
        bus.resp_data_o  = '0;
        bus.mac_ready_o  = 1'b0;
        if (nonempty_s) begin
            bus.resp_valid_o = (one_lp << head_s) & {num_ch_p{bus.mac_valid_i}};
            bus.resp_data_o  = bus.mac_data_i;
            bus.mac_ready_o  = bus.resp_ready_i[head_s];
        end else begin
            bus.mac_ready_o  = 1'b0;
        end
        bus.busy_o = (state_r == BURST) | nonempty_s;
        bus.err_o  = err_r;
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            lock_r  <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            lock_r  <= lock_s;
        end
    end

    // Tag FIFO: push the grant on issue, pop on result transfer; pointers wrap naturally.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_r  <= '0;
            rd_r  <= '0;
            cnt_r <= '0;
            for (int i = 0; i < tag_depth_p; i++) begin
                tags_r[i] <= '0;
            end
        end else begin
            if (issue_s) begin
                tags_r[wr_r] <= grant_s;
                wr_r         <= wr_r + 1'b1;
            end else begin
                wr_r         <= wr_r;
            end
            if (pop_s) begin
                rd_r <= rd_r + 1'b1;
            end else begin
                rd_r <= rd_r;
            end
            if (issue_s && !pop_s) begin
                cnt_r <= cnt_r + 1'b1;
            end else if (pop_s && !issue_s) begin
                cnt_r <= cnt_r - 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Sticky error: a MAC result arrived with nothing outstanding.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_r <= 1'b0;
        end else if (!nonempty_s && bus.mac_valid_i) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
endmodule

// File: tb/tb_mac_share_arbiter.sv
// Self-checking bench for mac_share_arbiter: directed scenarios plus randomized traffic,
// compared cycle by cycle against a queue-based reference model of the arbiter.
module tb_mac_share_arbiter;
    localparam int W = 24;
    localparam int N = 4;
    localparam int D = 4;

    typedef struct {
        int             ch;
        logic [W-1:0]   d;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int           ptr_m = 0;
    int           owner_m = -1;
    bit           err_m = 1'b0;
    ent_t         sb[$];
    logic [W-1:0] macq[$];
    int           iss_ch = -1;
    int           iss_log[$];
    int           rsp_ch_log[$];
    logic [W-1:0] rsp_data_log[$];

    always #5 clk = ~clk;

    mac_share_arbiter_if #(.width_p(W), .num_ch_p(N)) bus ();

    mac_share_arbiter #(.width_p(W), .num_ch_p(N), .tag_depth_p(D)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus.slave)
    );

    task automatic clear_inputs();
        bus.req_valid_i  = '0;
        bus.req_last_i   = '0;
        bus.req_data_i   = '0;
        bus.mac_ready_i  = 1'b1;
        bus.mac_valid_i  = 1'b0;
        bus.mac_data_i   = '0;
        bus.resp_ready_i = '1;
    endtask

    task automatic set_ch(input int k, input logic v, input logic l, input logic [W-1:0] d);
        bus.req_valid_i[k]       = v;
        bus.req_last_i[k]        = l;
        bus.req_data_i[k*W +: W] = d;
    endtask

    task automatic drive_mac(input bit always_on);
        if (macq.size() > 0 && (always_on || $urandom_range(0, 3) != 0)) begin
            bus.mac_valid_i = 1'b1;
            bus.mac_data_i  = macq[0];
        end else begin
            bus.mac_valid_i = 1'b0;
            bus.mac_data_i  = W'($urandom);
        end
    endtask

    task automatic model_reset();
        ptr_m = 0;
        owner_m = -1;
        err_m = 1'b0;
        sb.delete();
        macq.delete();
    endtask

    // One clock cycle: compare all outputs against the model, then advance the model.
    task automatic step();
        int g, h;
        logic [N-1:0] e_rdy, e_rv;
        logic e_mv, e_mr, e_busy, lst;
        logic [W-1:0] e_md, e_rd, dd;
        bit can, issue, pop, empty0;
        #1;
        g = -1;
        if (owner_m >= 0) begin
            g = owner_m;
        end else begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (ptr_m + i) % N;
                if (g < 0 && bus.req_valid_i[c]) g = c;
            end
        end
        can = bus.mac_ready_i && (sb.size() < D);
        e_rdy = '0; e_mv = 1'b0; e_md = '0; lst = 1'b0; dd = '0;
        if (g >= 0) begin
            e_rdy[g] = can;
            e_mv = bus.req_valid_i[g];
            e_md = bus.req_data_i[g*W +: W];
            lst  = bus.req_last_i[g];
            dd   = e_md;
        end
        e_rv = '0; e_mr = 1'b0; e_rd = '0; h = -1;
        if (sb.size() > 0) begin
            h = sb[0].ch;
            e_rv[h] = bus.mac_valid_i;
            e_mr = bus.resp_ready_i[h];
            e_rd = bus.mac_data_i;
        end
        e_busy = (owner_m >= 0) || (sb.size() > 0);

        checks += 8;
        if (bus.req_ready_o !== e_rdy) begin errors++; $display("FAIL req_ready: got %b expected %b", bus.req_ready_o, e_rdy); end
        if (bus.mac_valid_o !== e_mv) begin errors++; $display("FAIL mac_valid: got %b expected %b", bus.mac_valid_o, e_mv); end
        if (bus.mac_data_o !== e_md) begin errors++; $display("FAIL mac_data: got %h expected %h", bus.mac_data_o, e_md); end
        if (bus.resp_valid_o !== e_rv) begin errors++; $display("FAIL resp_valid: got %b expected %b", bus.resp_valid_o, e_rv); end
        if (bus.mac_ready_o !== e_mr) begin errors++; $display("FAIL mac_ready: got %b expected %b", bus.mac_ready_o, e_mr); end
        if (bus.resp_data_o !== e_rd) begin errors++; $display("FAIL resp_data: got %h expected %h", bus.resp_data_o, e_rd); end
        if (bus.busy_o !== e_busy) begin errors++; $display("FAIL busy: got %b expected %b", bus.busy_o, e_busy); end
        if (bus.err_o !== err_m) begin errors++; $display("FAIL err: got %b expected %b", bus.err_o, err_m); end

        issue = (g >= 0) && bus.req_valid_i[g] && e_rdy[g];
        pop = (h >= 0) && bus.mac_valid_i && bus.resp_ready_i[h];
        empty0 = (sb.size() == 0);
        iss_ch = issue ? g : -1;
        if (pop) begin
            checks++;
            if (bus.resp_data_o !== sb[0].d) begin
                errors++;
                $display("FAIL resp_sample ch%0d: got %h expected %h", h, bus.resp_data_o, sb[0].d);
            end
            rsp_ch_log.push_back(h);
            rsp_data_log.push_back(bus.resp_data_o);
        end
        if (issue) iss_log.push_back(g);

        @(posedge clk);
        if (empty0 && bus.mac_valid_i) err_m = 1'b1;
        if (pop) begin
            sb.delete(0);
            macq.delete(0);
        end
        if (issue) begin
            sb.push_back('{ch: g, d: dd});
            macq.push_back(dd);
            if (owner_m < 0) begin
                if (lst) ptr_m = (g + 1) % N;
                else owner_m = g;
            end else if (lst) begin
                owner_m = -1;
                ptr_m = (g + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    // Let everything outstanding return and close any open burst, within a cycle budget.
    task automatic drain();
        int n;
        n = 0;
        bus.mac_ready_i = 1'b1;
        bus.resp_ready_i = '1;
        while ((sb.size() > 0 || owner_m >= 0) && n < 64) begin
            bus.req_valid_i = '0;
            bus.req_last_i = '1;
            if (owner_m >= 0) bus.req_valid_i[owner_m] = 1'b1;
            drive_mac(1'b1);
            step();
            n++;
        end
        clear_inputs();
        checks++;
        if (sb.size() != 0 || owner_m >= 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.req_valid_i = '1;
        bus.mac_valid_i = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.req_ready_o, bus.mac_valid_o, bus.mac_data_o, bus.resp_valid_o, bus.mac_ready_o,
             bus.resp_data_o, bus.busy_o, bus.err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs, expected all 0 (req_ready=%b mac_valid=%b)",
                     bus.req_ready_o, bus.mac_valid_o);
        end
        @(negedge clk);
        clear_inputs();
        reset_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_single_channel();
        logic [W-1:0] beats [3];
        beats[0] = 24'd100; beats[1] = 24'd200; beats[2] = 24'd300;
        rsp_ch_log.delete(); rsp_data_log.delete();
        for (int b = 0; b < 3; b++) begin
            clear_inputs();
            set_ch(1, 1'b1, (b == 2), beats[b]);
            drive_mac(1'b1);
            step();
            checks++;
            if (iss_ch != 1) begin errors++; $display("FAIL single_issue: got ch%0d expected ch1", iss_ch); end
        end
        drain();
        checks++;
        if (rsp_ch_log.size() != 3) begin
            errors++; $display("FAIL single_resp_count: got %0d expected 3", rsp_ch_log.size());
        end else begin
            for (int b = 0; b < 3; b++) begin
                checks++;
                if (rsp_ch_log[b] != 1 || rsp_data_log[b] !== beats[b]) begin
                    errors++;
                    $display("FAIL single_resp: got ch%0d %0d expected ch1 %0d", rsp_ch_log[b], rsp_data_log[b], beats[b]);
                end
            end
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", bus.busy_o); end
        bus.req_valid_i = '1; bus.req_last_i = '1;
        step();
        checks++;
        if (iss_ch != 2) begin errors++; $display("FAIL single_ptr: got ch%0d expected ch2", iss_ch); end
        drain();
    endtask

    task automatic test_round_robin();
        int exp_order [5];
        int exp_rsp [6];
        exp_order = '{0, 1, 2, 3, 0};
        exp_rsp = '{3, 0, 1, 2, 3, 0};
        rsp_ch_log.delete();
        clear_inputs();
        set_ch(3, 1'b1, 1'b1, 24'h000333);
        step();
        iss_log.delete();
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < N; k++) set_ch(k, 1'b1, 1'b1, W'(k * 16 + c));
            drive_mac(1'b1);
            step();
        end
        drain();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (c >= iss_log.size() || iss_log[c] != exp_order[c]) begin
                errors++; $display("FAIL rr_order[%0d]: got ch%0d expected ch%0d", c, (c < iss_log.size()) ? iss_log[c] : -1, exp_order[c]);
            end
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (c >= rsp_ch_log.size() || rsp_ch_log[c] != exp_rsp[c]) begin
                errors++; $display("FAIL rr_route[%0d]: got ch%0d expected ch%0d", c, (c < rsp_ch_log.size()) ? rsp_ch_log[c] : -1, exp_rsp[c]);
            end
        end
    endtask

    task automatic test_burst_lock();
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            set_ch(0, 1'b1, (c == 3), W'(500 + c));
            set_ch(2, (c != 0), 1'b0, 24'h00A2A2);
            drive_mac(1'b1);
            #1;
            checks++;
            if (bus.req_ready_o[2] !== 1'b0) begin errors++; $display("FAIL lock_ready2[%0d]: got %b expected 0", c, bus.req_ready_o[2]); end
            step();
            checks++;
            if (iss_ch != 0) begin errors++; $display("FAIL lock_issue[%0d]: got ch%0d expected ch0", c, iss_ch); end
        end
        set_ch(0, 1'b1, 1'b1, 24'd600);
        set_ch(2, 1'b1, 1'b1, 24'h00A2A2);
        drive_mac(1'b1);
        step();
        checks++;
        if (iss_ch != 2) begin errors++; $display("FAIL lock_handover: got ch%0d expected ch2", iss_ch); end
        drain();
    endtask

    task automatic test_back_pressure_full();
        int n_iss;
        clear_inputs();
        bus.resp_ready_i = '0;
        n_iss = 0;
        for (int c = 0; c < 6; c++) begin
            set_ch(1, 1'b1, 1'b1, W'(700 + c));
            drive_mac(1'b1);
            step();
            if (iss_ch >= 0) n_iss++;
        end
        checks++;
        if (n_iss != 4) begin errors++; $display("FAIL full_issues: got %0d expected 4", n_iss); end
        checks++;
        if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL full_ready: got %b expected 0000", bus.req_ready_o); end
        bus.resp_ready_i = 4'b0010;
        drive_mac(1'b1);
        step();
        checks++;
        if (iss_ch != -1) begin errors++; $display("FAIL full_no_bypass: got ch%0d expected none", iss_ch); end
        bus.resp_ready_i = 4'b0000;
        drive_mac(1'b1);
        step();
        checks++;
        if (iss_ch != 1) begin errors++; $display("FAIL full_one_more: got ch%0d expected ch1", iss_ch); end
        drive_mac(1'b1);
        step();
        checks++;
        if (iss_ch != -1) begin errors++; $display("FAIL full_refill: got ch%0d expected none", iss_ch); end
        drain();
    endtask

    task automatic test_last_contention();
        clear_inputs();
        set_ch(2, 1'b1, 1'b1, 24'd42);
        step();
        for (int c = 0; c < 2; c++) begin
            set_ch(3, 1'b1, 1'b1, 24'd33);
            set_ch(0, 1'b1, 1'b1, 24'd11);
            set_ch(2, 1'b0, 1'b0, 24'd0);
            drive_mac(1'b1);
            step();
            checks++;
            if (iss_ch != ((c == 0) ? 3 : 0)) begin
                errors++; $display("FAIL contention[%0d]: got ch%0d expected ch%0d", c, iss_ch, (c == 0) ? 3 : 0);
            end
        end
        drain();
    endtask

    task automatic test_error_reset();
        clear_inputs();
        bus.mac_valid_i = 1'b1;
        bus.mac_data_i = 24'hBAD000;
        step();
        checks += 2;
        if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus.err_o); end
        if (bus.mac_ready_o !== 1'b0) begin errors++; $display("FAIL err_mac_ready: got %b expected 0", bus.mac_ready_o); end
        bus.mac_valid_i = 1'b0;
        step();
        checks++;
        if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus.err_o); end
        set_ch(0, 1'b1, 1'b0, 24'd900);
        step();
        bus.req_valid_i = '1;
        bus.req_last_i = '0;
        bus.mac_valid_i = 1'b1;
        bus.mac_data_i = macq[0];
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready_o, bus.mac_valid_o, bus.mac_data_o, bus.resp_valid_o, bus.mac_ready_o,
             bus.resp_data_o, bus.busy_o, bus.err_o} !== '0) begin
            errors++;
            $display("FAIL midburst_reset: got busy=%b err=%b mac_valid=%b req_ready=%b expected all 0",
                     bus.busy_o, bus.err_o, bus.mac_valid_o, bus.req_ready_o);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_inputs();
        bus.req_valid_i = '1;
        bus.req_last_i = '1;
        step();
        checks++;
        if (iss_ch != 0) begin errors++; $display("FAIL reset_ptr: got ch%0d expected ch0", iss_ch); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                set_ch(k, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), W'($urandom));
                bus.resp_ready_i[k] = ($urandom_range(0, 3) != 0);
            end
            bus.mac_ready_i = ($urandom_range(0, 3) != 0);
            drive_mac(1'b0);
            step();
        end
        drain();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_channel();
        test_round_robin();
        test_burst_lock();
        test_back_pressure_full();
        test_last_contention();
        test_error_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_share_arbiter.md
Name: mac_share_arbiter

Overview:
- Shares one valid/ready MAC filter datapath (width_p-bit signed stream in, width_p-bit signed stream out) among num_ch_p requester channels.
- Arbitration is round-robin at burst granularity: a granted channel keeps the MAC until its last beat, so its samples pass through the filter contiguously.
- A tag FIFO records the issuing channel of every sample sent to the MAC and routes each MAC result back to that channel in order.

Parameters:
- width_p, 24, sample width (signed); matches the MAC datapath.
- num_ch_p, 4, number of requester channels (2..8).
- tag_depth_p, 4, tag FIFO entries; upper bound on samples in flight inside the MAC (power of two, >=2).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- req_valid_i  in  num_ch_p  per-channel sample valid.
- req_last_i  in  num_ch_p  per-channel last-beat-of-burst flag, qualified by valid.
- req_data_i  in  num_ch_p*width_p  per-channel signed samples; channel k at bits [k*width_p +: width_p].
- req_ready_o  out  num_ch_p  per-channel accept.
- mac_valid_o  out  1  sample valid to MAC.
- mac_data_o  out  width_p  sample to MAC.
- mac_ready_i  in  1  MAC accept.
- mac_valid_i  in  1  MAC result valid.
- mac_data_i  in  width_p  MAC result.
- mac_ready_o  out  1  result accept to MAC.
- resp_valid_o  out  num_ch_p  per-channel result valid (one-hot or zero).
- resp_data_o  out  width_p  result data, shared by all channels.
- resp_ready_i  in  num_ch_p  per-channel result accept.
- busy_o  out  1  high in BURST state or while the tag FIFO is non-empty.
- err_o  out  1  sticky: MAC presented a result while the tag FIFO was empty.

Behaviour:
- Reset (reset_n_i=0, async): state=IDLE, rr pointer=0, lock id=0, tag FIFO empty, err_o=0. All outputs are 0 while reset is held.
- Issue condition: can_issue = mac_ready_i && !tag_full. A beat transfers on the issue path when req_valid_i[g] && req_ready_o[g], where g is the current grant.
- FSM IDLE:
  - g is the first channel with req_valid_i set, searching from the rr pointer upward and wrapping modulo num_ch_p. If no channel is valid, there is no grant and all outputs are 0.
  - Grant is combinational. mac_valid_o=req_valid_i[g], mac_data_o=req_data_i[g], req_ready_o=onehot(g) & can_issue. This gives 0-cycle latency.
  - Transfer with req_last_i[g]=1: stay IDLE and set pointer to (g+1) mod num_ch_p.
  - Transfer with req_last_i[g]=0: set lock to g and go to BURST.
  - No transfer: pointer unchanged; re-arbitrate next cycle.
- FSM BURST:
  - Only channel lock is muxed. All other req_ready_o bits are 0, regardless of their valid.
  - A transfer with last=1 goes to IDLE and sets pointer to (lock+1) mod num_ch_p. A transfer with last=0 stays in BURST.
  - req_valid_i[lock] may drop mid-burst; the lock holds with no timeout.
- Valid/ready rule: mac_valid_o must not depend on mac_ready_i. It may depend on tag_full only through req_ready_o, never through mac_valid_o.
- Tag FIFO:
  - Push the grant id on every issue transfer; pop on every result transfer.
  - tag_full blocks issue; there is no bypass when a pop happens in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - Read and write pointers wrap modulo tag_depth_p.
- Result path, FIFO non-empty with head tag h:
  - resp_valid_o=onehot(h) & {num_ch_p{mac_valid_i}}, resp_data_o=mac_data_i, mac_ready_o=resp_ready_i[h].
  - A stalled channel h back-pressures the MAC and therefore every channel (in-order, head-of-line).
- Result path, FIFO empty: mac_ready_o=0 and resp_valid_o=0. If mac_valid_i=1, err_o sets and stays set until reset.
- Reset asserted mid-burst or mid-flight: all state clears immediately and in-flight tags are discarded. The MAC is reset alongside by the integrator.
- MAC filter state carries across bursts. Per-channel state isolation is the requesters' responsibility.

Test Plan:
- Single channel: ch1 sends 3-beat burst 100,200,300 (last on 300); MAC model echoes each input after 1 cycle → resp_valid_o=4'b0010 three times with data 100,200,300; pointer ends at 2; busy_o falls after the final result.
- Round-robin: all 4 channels valid with 1-beat bursts continuously, pointer=0 → grant order 0,1,2,3,0 on consecutive cycles; each response returns to the matching channel.
- Burst lock: ch0 starts a 4-beat burst while ch2 is valid throughout → req_ready_o[2]=0 until ch0's last beat transfers; ch2 is granted on the next cycle; no ch2 beat is interleaved.
- Back-pressure/full: tag_depth_p=4, mac_ready_i=1, resp_ready_i=0 with MAC results pending → exactly 4 issues, then req_ready_o=0. Raising resp_ready_i[head] pops one tag and permits exactly one further issue the following cycle.
- Error and reset: drive mac_valid_i=1 with the FIFO empty → err_o=1, mac_ready_o=0, and err_o stays 1. Pulse reset_n_i low mid-burst → err_o=0, state IDLE, pointer 0, all outputs 0 asynchronously.
- Last on first beat under contention: ch3 valid+last and ch0 valid, pointer=3 → ch3 issues, pointer becomes 0, ch0 is granted the next cycle.
